mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive data grants allowed while an instruction fetch waits.
REQ-002 SHALL have port CLK  input  1  system clock, rising-edge active.
REQ-003 SHALL have port RST  input  1  asynchronous reset, active-high.
REQ-004 SHALL have ports iREN  input  1 and iaddr  input  32: instruction read request and word address.
REQ-005 SHALL have ports dREN  input  1 and dWEN  input  1: data read and data write requests.
REQ-006 SHALL have ports daddr  input  32 and dstore  input  32: data address and write data.
REQ-007 SHALL have ports iwait  output  1 and iload  output  32: instruction stall and fetched word.
REQ-008 SHALL have ports dwait  output  1 and dload  output  32: data stall and loaded word.
REQ-009 SHALL have ports ramREN  output  1, ramWEN  output  1, ramaddr  output  32 and ramstore  output  32: single shared RAM port.
REQ-010 SHALL have ports ramload  input  32 and ramstate  input  2, where 0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR.

Function
REQ-011 SHALL implement an FSM with states IDLE, DGNT and IGNT; RAM port active only in DGNT/IGNT.
REQ-012 SHALL, in IDLE with a data request (dREN|dWEN) pending and NOT (iREN and starve_cnt==STARVE_LIMIT), latch daddr, dstore, dWEN and enter DGNT next cycle.
REQ-013 SHALL, in IDLE otherwise with iREN high, latch iaddr and enter IGNT next cycle.
REQ-014 SHALL treat dREN=dWEN=1 as a write.
REQ-015 SHALL drive ramaddr/ramstore/ramWEN/ramREN from latched values only, constant for the whole grant; ramREN=~latched dWEN in DGNT, ramREN=1 and ramWEN=0 in IGNT, all 0 and ramaddr/ramstore 0 in IDLE.
REQ-016 SHALL hold iwait=1 and dwait=1 except in the single completion cycle of the respective grant.
REQ-017 SHALL complete a grant in the cycle ramstate==ACCESS: deassert the matching wait combinationally, drive ramload onto iload (IGNT) or dload (DGNT, read), and return to IDLE next cycle.
REQ-018 SHALL keep iload and dload at 0 outside their completion cycle.
REQ-019 SHALL, in the cycle ramstate==ERROR, keep waits high, return to IDLE next cycle and re-arbitrate (retry) without a completion.
REQ-020 SHALL abort a grant (IDLE next cycle, no completion, waits stay high) if the granted requester withdraws its request mid-grant.
REQ-021 SHALL hold state while ramstate is FREE or BUSY in a grant; no timeout.
REQ-022 SHALL have minimum request-to-completion latency of 2 cycles (request sampled in IDLE, ACCESS in first grant cycle) and one IDLE cycle between back-to-back grants.
REQ-023 SHALL keep starve_cnt (width clog2(STARVE_LIMIT+1)): increment, saturating at STARVE_LIMIT, on each data completion with iREN high; clear on each instruction completion; unchanged otherwise.
REQ-024 SHALL give instruction priority in IDLE when iREN is high and starve_cnt==STARVE_LIMIT, even with a data request pending.

Reset
REQ-025 SHALL on RST=1, immediately and regardless of CLK, enter IDLE, clear starve_cnt and all latched registers, producing ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, iload=dload=0.
REQ-026 SHALL abandon any in-flight grant on reset with no completion signalled, then resume arbitration on the first CLK edge after RST falls.

Verification
REQ-027 SHALL verify lone fetch: iREN=1, iaddr=0x40, RAM ACCESS on first grant cycle with ramload=0x2401000A -> ramREN=1, ramaddr=0x40, iwait=0 for one cycle with iload=0x2401000A at cycle 2.
REQ-028 SHALL verify data priority: iREN=1 and dWEN=1 (daddr=0x80, dstore=0xDEADBEEF) together -> DGNT first with ramWEN=1, ramaddr=0x80, ramstore=0xDEADBEEF; IGNT after dwait drops.
REQ-029 SHALL verify starvation: STARVE_LIMIT=4, iREN and dREN held high -> exactly 4 data completions, then an instruction completion, then starve_cnt=0 and data grant again.
REQ-030 SHALL verify error retry: ramstate=ERROR in DGNT -> dwait stays 1, IDLE next cycle, data re-granted with same daddr, completes on subsequent ACCESS.
REQ-031 SHALL verify BUSY stretching and reset: ramstate=BUSY for 5 cycles holds ramaddr constant and waits high; RST asserted mid-grant -> outputs at reset values in the same cycle, no completion.
REQ-032 SHALL verify withdrawal: dREN dropped during DGNT -> IDLE next cycle, dwait never deasserted, pending iREN granted afterward.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates one shared RAM port between an instruction fetch port and a data port.
// Latency: request sampled in IDLE, earliest completion in the next (first grant) cycle.
// Backpressure: iwait/dwait stay high until the RAM reports ACCESS; BUSY/FREE stretch a grant.
// Ports:
//   CLK, RST                    clock, async active-high reset
//   iREN, iaddr / iwait, iload  instruction fetch request, address / stall, fetched word
//   dREN, dWEN, daddr, dstore   data read/write request, address, write data
//   dwait, dload                data stall, loaded word
//   ramREN, ramWEN, ramaddr,    shared RAM request port (driven from latched values only)
//   ramstore, ramload, ramstate RAM write data, read data, status (FREE/BUSY/ACCESS/ERROR)
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic [31:0] iload,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  localparam logic [1:0] RAM_FREE   = 2'd0;
  localparam logic [1:0] RAM_BUSY   = 2'd1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DGNT = 2'd1,
    IGNT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      store_q, store_d;
  logic             wen_q, wen_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  logic data_req;
  logic starve_hit;

  assign data_req   = dREN | dWEN;
  // Instruction fetch has waited through the allowed number of data grants.
  assign starve_hit = iREN && (starve_cnt_q == LIMIT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      store_q      <= '0;
      wen_q        <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      store_q      <= store_d;
      wen_q        <= wen_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    store_d      = store_q;
    wen_d        = wen_q;
    starve_cnt_d = starve_cnt_q;
    iwait        = 1'b1;
    dwait        = 1'b1;
    iload        = '0;
    dload        = '0;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;

    unique case (state_q)
      IDLE: begin
        if (data_req && !starve_hit) begin
          addr_d  = daddr;
          store_d = dstore;
          // A simultaneous read and write is handled as a write.
          wen_d   = dWEN;
          state_d = DGNT;
        end else if (iREN) begin
          addr_d  = iaddr;
          store_d = '0;
          wen_d   = 1'b0;
          state_d = IGNT;
        end
      end

      DGNT: begin
        ramREN   = ~wen_q;
        ramWEN   = wen_q;
        ramaddr  = addr_q;
        ramstore = store_q;
        if (!data_req) begin
          // Requester withdrew: drop the grant without completing it.
          state_d = IDLE;
        end else begin
          unique case (ramstate)
            RAM_ACCESS: begin
              dwait   = 1'b0;
              dload   = wen_q ? 32'h0 : ramload;
              state_d = IDLE;
              if (iREN && (starve_cnt_q != LIMIT)) begin
                starve_cnt_d = starve_cnt_q + ONE;
              end
            end
            RAM_ERROR: state_d = IDLE;  // retried through normal arbitration
            RAM_FREE, RAM_BUSY: state_d = DGNT;
            default: state_d = DGNT;
          endcase
        end
      end

      IGNT: begin
        ramREN  = 1'b1;
        ramaddr = addr_q;
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          unique case (ramstate)
            RAM_ACCESS: begin
              iwait        = 1'b0;
              iload        = ramload;
              state_d      = IDLE;
              starve_cnt_d = '0;
            end
            RAM_ERROR: state_d = IDLE;
            RAM_FREE, RAM_BUSY: state_d = IGNT;
            default: state_d = IGNT;
          endcase
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        iwait;
  logic [31:0] iload;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .iwait    (iwait),
    .iload    (iload),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and
  // outputs sampled 1 time unit later, well clear of either edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    RST = 1'b1; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    #2;
    chk("rst_ramREN", {31'b0, ramREN}, 32'h0);
    chk("rst_ramWEN", {31'b0, ramWEN}, 32'h0);
    chk("rst_iwait",  {31'b0, iwait},  32'h1);
    chk("rst_dwait",  {31'b0, dwait},  32'h1);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_iload",   iload,   32'h0);
    step();
    RST = 1'b0;

    // Lone fetch
    iREN = 1'b1; iaddr = 32'h40; settle();
    chk("fetch_idle_ramREN", {31'b0, ramREN}, 32'h0);
    chk("fetch_idle_iwait",  {31'b0, iwait},  32'h1);
    step();
    ramstate = ACCESS; ramload = 32'h2401000A; settle();
    chk("fetch_ramREN",  {31'b0, ramREN}, 32'h1);
    chk("fetch_ramWEN",  {31'b0, ramWEN}, 32'h0);
    chk("fetch_ramaddr", ramaddr, 32'h40);
    chk("fetch_iwait",   {31'b0, iwait},  32'h0);
    chk("fetch_iload",   iload, 32'h2401000A);
    step();
    iREN = 1'b0; ramstate = FREE; settle();
    chk("fetch_after_iwait",  {31'b0, iwait},  32'h1);
    chk("fetch_after_iload",  iload, 32'h0);
    chk("fetch_after_ramREN", {31'b0, ramREN}, 32'h0);

    // Data priority over a simultaneous fetch; write completion
    iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEADBEEF;
    step();
    ramstate = ACCESS; ramload = 32'h12345678; settle();
    chk("prio_ramWEN",   {31'b0, ramWEN}, 32'h1);
    chk("prio_ramREN",   {31'b0, ramREN}, 32'h0);
    chk("prio_ramaddr",  ramaddr,  32'h80);
    chk("prio_ramstore", ramstore, 32'hDEADBEEF);
    chk("prio_dwait",    {31'b0, dwait}, 32'h0);
    chk("prio_dload",    dload, 32'h0);
    chk("prio_iwait",    {31'b0, iwait}, 32'h1);
    step();
    dWEN = 1'b0; settle();
    chk("prio_starve1", {29'b0, dut.starve_cnt_q}, 32'h1);
    step();
    settle();
    chk("prio_ig_ramaddr", ramaddr, 32'h44);
    chk("prio_ig_iwait",   {31'b0, iwait}, 32'h0);
    step();
    iREN = 1'b0; settle();
    chk("prio_starve0", {29'b0, dut.starve_cnt_q}, 32'h0);

    // dREN and dWEN together act as a write
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h90; dstore = 32'h0000BEEF;
    step();
    settle();
    chk("rw_ramWEN", {31'b0, ramWEN}, 32'h1);
    chk("rw_ramREN", {31'b0, ramREN}, 32'h0);
    chk("rw_dload",  dload, 32'h0);
    step();
    dREN = 1'b0; dWEN = 1'b0; settle();

    // Starvation: expect D D D D I D with both requests held
    iREN = 1'b1; iaddr = 32'h200; dREN = 1'b1; daddr = 32'h300; ramstate = ACCESS;
    for (int g = 0; g < 6; g++) begin
      automatic logic exp_i = (g == 4);
      ramload = 32'hA000_0000 + g;
      settle();
      chk("starve_idle_ramREN", {31'b0, ramREN}, 32'h0);
      step();
      settle();
      chk("starve_iwait",   {31'b0, iwait}, exp_i ? 32'h0 : 32'h1);
      chk("starve_dwait",   {31'b0, dwait}, exp_i ? 32'h1 : 32'h0);
      chk("starve_ramaddr", ramaddr, exp_i ? 32'h200 : 32'h300);
      chk(exp_i ? "starve_iload" : "starve_dload", exp_i ? iload : dload, 32'hA000_0000 + g);
      step();
      if (g == 3) chk("starve_cnt_sat", {29'b0, dut.starve_cnt_q}, 32'h4);
      if (g == 4) chk("starve_cnt_clr", {29'b0, dut.starve_cnt_q}, 32'h0);
    end
    iREN = 1'b0; dREN = 1'b0; ramstate = FREE; settle();
    step();

    // Error retry
    dREN = 1'b1; daddr = 32'h100;
    step();
    ramstate = ERROR; settle();
    chk("err_dwait",   {31'b0, dwait}, 32'h1);
    chk("err_dload",   dload, 32'h0);
    chk("err_ramaddr", ramaddr, 32'h100);
    step();
    ramstate = FREE; settle();
    chk("err_idle_ramREN", {31'b0, ramREN}, 32'h0);
    step();
    ramstate = ACCESS; ramload = 32'h55; settle();
    chk("err_retry_ramaddr", ramaddr, 32'h100);
    chk("err_retry_dwait",   {31'b0, dwait}, 32'h0);
    chk("err_retry_dload",   dload, 32'h55);
    step();
    dREN = 1'b0; ramstate = FREE; settle();

    // BUSY stretching then reset mid-grant
    dREN = 1'b1; daddr = 32'h400;
    step();
    ramstate = BUSY;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("busy_ramaddr", ramaddr, 32'h400);
      chk("busy_dwait",   {31'b0, dwait}, 32'h1);
      chk("busy_iwait",   {31'b0, iwait}, 32'h1);
      step();
    end
    ramstate = ACCESS; ramload = 32'h77; RST = 1'b1; settle();
    chk("rst_mid_ramREN",  {31'b0, ramREN}, 32'h0);
    chk("rst_mid_ramaddr", ramaddr, 32'h0);
    chk("rst_mid_dwait",   {31'b0, dwait}, 32'h1);
    chk("rst_mid_dload",   dload, 32'h0);
    step();
    RST = 1'b0; settle();
    chk("rst_rel_ramREN", {31'b0, ramREN}, 32'h0);
    step();
    settle();
    chk("rst_resume_ramaddr", ramaddr, 32'h400);
    chk("rst_resume_dload",   dload, 32'h77);
    step();
    dREN = 1'b0; ramstate = FREE; settle();

    // Withdrawal during a data grant
    iREN = 1'b1; iaddr = 32'h600; dREN = 1'b1; daddr = 32'h500;
    step();
    settle();
    chk("wd_ramaddr", ramaddr, 32'h500);
    dREN = 1'b0; ramstate = ACCESS; ramload = 32'h99; settle();
    chk("wd_dwait", {31'b0, dwait}, 32'h1);
    chk("wd_dload", dload, 32'h0);
    step();
    settle();
    chk("wd_idle_ramREN", {31'b0, ramREN}, 32'h0);
    chk("wd_idle_dwait",  {31'b0, dwait}, 32'h1);
    step();
    settle();
    chk("wd_ig_ramaddr", ramaddr, 32'h600);
    chk("wd_ig_iwait",   {31'b0, iwait}, 32'h0);
    chk("wd_ig_iload",   iload, 32'h99);
    step();
    iREN = 1'b0; ramstate = FREE;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
